// File: rtl/axis_data_check.sv
// AXI4-Stream frame checker: sinks one armed frame, verifies an incrementing
// data pattern and tlast position, and reports pass/fail with a done pulse.
//
// state | meaning
// IDLE  | not armed; o_ready low, stream ignored
// RECV  | receiving and checking beats 0..length-1
// DRAIN | length reached without tlast; swallow beats until tlast
module axis_data_check #(
  parameter int DATA_WIDTH    = 64,
  parameter int LENGTH_WIDTH  = 9,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      sys_arstn,
  input  logic                      i_start,
  input  logic [LENGTH_WIDTH-1:0]   i_length,
  input  logic                      i_hold,
  input  logic [DATA_WIDTH-1:0]     i_data,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH/8-1:0]   i_keep,
  input  logic                      i_last,
  output logic                      o_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic                      o_err_data,
  output logic                      o_err_len,
  output logic [LENGTH_WIDTH-1:0]   o_beat_cnt,
  output logic [ERR_CNT_WIDTH-1:0]  o_err_cnt,
  output logic [LENGTH_WIDTH-1:0]   o_first_err_idx
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [LENGTH_WIDTH-1:0]  len_q, beat_cnt_q, first_err_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic                     err_data_q, err_len_q, pass_q, done_q;
  logic                     err_data_d, err_len_d;
  logic                     accept, start_ok, at_end, mismatch, terminate;

  assign o_ready  = (state_q != IDLE) & ~i_hold;
  assign o_busy   = (state_q != IDLE);
  assign accept   = i_valid & o_ready;
  assign start_ok = (state_q == IDLE) & i_start & (i_length != '0);
  assign at_end   = (beat_cnt_q == len_q - LENGTH_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    err_data_d = err_data_q;
    err_len_d  = err_len_q;
    mismatch   = 1'b0;
    terminate  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = RECV;
      end
      RECV: begin
        if (accept) begin
          mismatch = (i_data != DATA_WIDTH'(beat_cnt_q)) | (i_keep != '1);
          if (mismatch) err_data_d = 1'b1;
          if (i_last) begin
            terminate = 1'b1;
            state_d   = IDLE;
            if (!at_end) err_len_d = 1'b1;
          end else if (at_end) begin
            err_len_d = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && i_last) begin
          terminate = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      first_err_q <= '0;
      err_cnt_q   <= '0;
      err_data_q  <= 1'b0;
      err_len_q   <= 1'b0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= terminate;
      err_data_q <= err_data_d;
      err_len_q  <= err_len_d;
      if (start_ok) begin
        len_q       <= i_length;
        beat_cnt_q  <= '0;
        err_cnt_q   <= '0;
        first_err_q <= '0;
        err_data_q  <= 1'b0;
        err_len_q   <= 1'b0;
        pass_q      <= 1'b0;
      end
      if (accept && state_q == RECV) begin
        beat_cnt_q <= beat_cnt_q + LENGTH_WIDTH'(1);
        if (mismatch) begin
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
          // err_data_q still low means this is the frame's first bad beat
          if (!err_data_q) first_err_q <= beat_cnt_q;
        end
      end
      if (accept && state_q == DRAIN && beat_cnt_q != '1)
        beat_cnt_q <= beat_cnt_q + LENGTH_WIDTH'(1);
      if (terminate) pass_q <= ~err_data_d & ~err_len_d;
    end
  end

  assign o_done          = done_q;
  assign o_pass          = pass_q;
  assign o_err_data      = err_data_q;
  assign o_err_len       = err_len_q;
  assign o_beat_cnt      = beat_cnt_q;
  assign o_err_cnt       = err_cnt_q;
  assign o_first_err_idx = first_err_q;

endmodule

// File: tb/tb_axis_data_check.sv
// Self-checking bench for axis_data_check: directed frame table, hand-written
// reset/arming sequences and randomized frames against a frame-level model.
module tb_axis_data_check;
  localparam int DW = 64;
  localparam int LW = 9;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          sys_arstn;
  logic          i_start, i_hold, i_valid, i_last;
  logic [LW-1:0] i_length;
  logic [DW-1:0] i_data;
  logic [7:0]    i_keep;
  logic          o_ready, o_busy, o_done, o_pass, o_err_data, o_err_len;
  logic [LW-1:0] o_beat_cnt, o_first_err_idx;
  logic [EW-1:0] o_err_cnt;

  always #5 clk = ~clk;

  axis_data_check #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .sys_arstn(sys_arstn), .i_start(i_start), .i_length(i_length),
    .i_hold(i_hold), .i_data(i_data), .i_valid(i_valid), .i_keep(i_keep),
    .i_last(i_last), .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done),
    .o_pass(o_pass), .o_err_data(o_err_data), .o_err_len(o_err_len),
    .o_beat_cnt(o_beat_cnt), .o_err_cnt(o_err_cnt), .o_first_err_idx(o_first_err_idx)
  );

  int    checks = 0;
  int    passed = 0;
  string tag = "init";

  logic [DW-1:0] fd [0:599];
  logic [7:0]    fk [0:599];
  logic          fl [0:599];
  int            nb;

  typedef struct {
    int len; int n; int ca; int cb; int kat;
    int hold_pct; int gap_pct; int restart_at;
    bit pass; bit ed; bit el; int bc; int ec; int fi;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s/%s: got %0d expected %0d", tag, name, act, exp);
  endtask

  task automatic build(int n, int ca, int cb, int kat);
    nb = n;
    for (int i = 0; i < n; i++) begin
      fd[i] = DW'(i);
      fk[i] = 8'hFF;
      fl[i] = (i == n - 1);
      if (i == ca || i == cb) fd[i] = 64'hFFFF;
      if (i == kat) fk[i] = 8'h7F;
    end
  endtask

  // Frame-level reference: first nb beats sent, last one carries tlast.
  task automatic model(int len, output bit pass, output bit ed, output bit el,
                       output int bc, output int ec, output int fi);
    ec = 0; fi = 0;
    for (int k = 0; k < nb; k++)
      if (k < len && (fd[k] != DW'(k) || fk[k] != 8'hFF)) begin
        if (ec == 0) fi = k;
        ec++;
      end
    ed   = (ec > 0);
    el   = (nb != len);
    bc   = (nb > 511) ? 511 : nb;
    pass = !ed && !el;
  endtask

  // Leaves time at posedge+1 of the cycle after the terminating beat.
  task automatic send_frame(int len, int hold_pct, int gap_pct, int restart_at);
    int  idx = 0;
    int  cyc = 0;
    bit  acc;
    bit  restarted = 0;
    @(negedge clk);
    i_start = 1'b1; i_length = LW'(len);
    @(negedge clk);
    i_start = 1'b0;
    chk("armed_busy", o_busy, 1);
    chk("armed_clear", {o_pass, o_err_data, o_err_len, o_beat_cnt, o_err_cnt, o_first_err_idx}, 0);
    forever begin
      i_hold  = ($urandom_range(0, 99) < hold_pct);
      i_valid = ($urandom_range(0, 99) >= gap_pct);
      i_data  = fd[idx]; i_keep = fk[idx]; i_last = fl[idx];
      i_start = 1'b0;
      if (idx == restart_at && !restarted) begin
        i_start = 1'b1; i_length = LW'(4); restarted = 1;
      end
      #1;
      if (o_ready !== !i_hold) chk("ready_vs_hold", o_ready, !i_hold);
      acc = i_valid && o_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
      if (idx == nb) break;
      if (cyc > 5000) begin
        chk("beat_timeout", idx, nb);
        break;
      end
      @(negedge clk);
    end
    i_valid = 1'b0; i_last = 1'b0; i_start = 1'b0; i_hold = 1'b0;
  endtask

  task automatic check_result(bit pass, bit ed, bit el, int bc, int ec, int fi);
    chk("done", o_done, 1);
    chk("pass", o_pass, pass);
    chk("err_data", o_err_data, ed);
    chk("err_len", o_err_len, el);
    chk("beat_cnt", o_beat_cnt, bc);
    chk("err_cnt", o_err_cnt, ec);
    chk("first_err_idx", o_first_err_idx, fi);
    @(posedge clk); #1;
    chk("done_one_cycle", o_done, 0);
    chk("idle_after", o_busy, 0);
    chk("pass_held", o_pass, pass);
  endtask

  initial begin
    bit p, ed, el;
    int bc, ec, fi, len, n, mode;

    tbl[0]  = '{256, 256, -1, -1, -1,  0,  0, -1, 1, 0, 0, 256, 0,  0};
    tbl[1]  = '{256, 256, -1, -1, -1, 40, 30, -1, 1, 0, 0, 256, 0,  0};
    tbl[2]  = '{256, 256, 10, 20, -1, 20, 10, -1, 0, 1, 0, 256, 2, 10};
    tbl[3]  = '{ 16,   8, -1, -1, -1,  0,  0, -1, 0, 0, 1,   8, 0,  0};
    tbl[4]  = '{ 16,  20, -1, -1, -1, 30, 20, -1, 0, 0, 1,  20, 0,  0};
    tbl[5]  = '{  4,   4, -1, -1,  2,  0,  0, -1, 0, 1, 0,   4, 1,  2};
    tbl[6]  = '{  8,   8,  0, -1, -1,  0,  0, -1, 0, 1, 0,   8, 1,  0};
    tbl[7]  = '{  1,   1, -1, -1, -1,  0,  0, -1, 1, 0, 0,   1, 0,  0};
    tbl[8]  = '{ 16,  16, -1, -1, -1, 20, 20,  3, 1, 0, 0,  16, 0,  0};
    tbl[9]  = '{511, 511, -1, -1, -1, 10, 10, -1, 1, 0, 0, 511, 0,  0};
    tbl[10] = '{500, 520, -1, -1, -1,  0,  0, -1, 0, 0, 1, 511, 0,  0};
    tbl[11] = '{  8,  10,  9, -1, -1,  0,  0, -1, 0, 0, 1,  10, 0,  0};

    sys_arstn = 1'b0;
    i_start = 0; i_length = '0; i_hold = 0; i_data = '0; i_valid = 0; i_keep = '0; i_last = 0;
    repeat (2) @(negedge clk);
    tag = "reset";
    chk("rst_outputs", {o_ready, o_busy, o_done, o_pass, o_err_data, o_err_len,
                        o_beat_cnt, o_err_cnt, o_first_err_idx}, 0);
    sys_arstn = 1'b1;

    tag = "len0";
    @(negedge clk);
    i_start = 1'b1; i_length = '0; i_valid = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_valid = 1'b0;
    chk("len0_ignored", {o_busy, o_ready}, 0);

    for (int r = 0; r < 12; r++) begin
      tag = $sformatf("row%0d", r);
      build(tbl[r].n, tbl[r].ca, tbl[r].cb, tbl[r].kat);
      send_frame(tbl[r].len, tbl[r].hold_pct, tbl[r].gap_pct, tbl[r].restart_at);
      check_result(tbl[r].pass, tbl[r].ed, tbl[r].el, tbl[r].bc, tbl[r].ec, tbl[r].fi);
    end

    tag = "midreset";
    build(16, -1, -1, -1);
    @(negedge clk);
    i_start = 1'b1; i_length = LW'(16);
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1; i_data = fd[i]; i_keep = fk[i]; i_last = 1'b0;
      @(posedge clk); #1;
    end
    chk("beats_before_rst", o_beat_cnt, 6);
    sys_arstn = 1'b0;
    #1;
    chk("rst_all_zero", {o_ready, o_busy, o_done, o_pass, o_err_data, o_err_len,
                         o_beat_cnt, o_err_cnt, o_first_err_idx}, 0);
    @(negedge clk);
    sys_arstn = 1'b1;
    @(posedge clk); #1;
    chk("no_done_after_rst", {o_done, o_busy}, 0);
    i_valid = 1'b0;
    build(4, -1, -1, -1);
    send_frame(4, 0, 0, -1);
    check_result(1, 0, 0, 4, 0, 0);

    for (int r = 0; r < 10; r++) begin
      tag = $sformatf("rand%0d", r);
      len  = $urandom_range(1, 40);
      mode = $urandom_range(0, 2);
      n    = (mode == 0) ? len : (mode == 1) ? $urandom_range(1, len) : len + $urandom_range(1, 5);
      build(n, -1, -1, -1);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 99) < 10) fd[i] = {$urandom, $urandom};
        if ($urandom_range(0, 99) < 5)  fk[i] = 8'($urandom_range(0, 254));
      end
      model(len, p, ed, el, bc, ec, fi);
      send_frame(len, $urandom_range(0, 50), $urandom_range(0, 50), -1);
      check_result(p, ed, el, bc, ec, fi);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
